hub75_scan_driver: RTL

HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

---
 rtl/hub75_scan_driver.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver
//   Scans a HUB75 RGB LED panel with binary-coded modulation. For each row
//   pair and each bit-plane it shifts one column line out of the framebuffer,
//   blanks, latches, then lights the row for a plane-weighted time scaled by
//   the global brightness.
//
//   Per plane: 1 fetch cycle + 2*COLUMNS shift cycles + BLANK + LATCH
//   + (DISP_BASE << p) display cycles.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   enable                scan frames while high; stops at a frame boundary
//   brightness[7:0]       global intensity, sampled once per plane at LATCH
//   fb_rd_en, fb_addr     framebuffer read strobe / {row, column} address
//   fb_data0, fb_data1    upper / lower half pixel {R,G,B}, 1 cycle after read
//   ADDR                  panel row address
//   OE                    panel output enable, active-low
//   LATCH                 panel latch strobe
//   RGB0, RGB1            panel colour bits {R,G,B}
//   clk_out               panel shift clock (panel samples on rising edge)
//   frame_done            one-cycle pulse after the last plane of the last row
module hub75_scan_driver #(
  parameter int COLUMNS   = 64,
  parameter int ROW_PAIRS = 16,
  parameter int BPP       = 4,
  parameter int DISP_BASE = 16,
  localparam int ADDR_W   = $clog2(ROW_PAIRS),
  localparam int COL_W    = $clog2(COLUMNS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [7:0]                brightness,
  output logic                      fb_rd_en,
  output logic [ADDR_W+COL_W-1:0]   fb_addr,
  input  logic [3*BPP-1:0]          fb_data0,
  input  logic [3*BPP-1:0]          fb_data1,
  output logic [ADDR_W-1:0]         ADDR,
  output logic                      OE,
  output logic                      LATCH,
  output logic [2:0]                RGB0,
  output logic [2:0]                RGB1,
  output logic                      clk_out,
  output logic                      frame_done
);

  localparam int P_W = (BPP > 1) ? $clog2(BPP) : 1;
  // Wide enough to hold the longest display time DISP_BASE << (BPP-1).
  localparam int T_W = $clog2((DISP_BASE << (BPP - 1)) + 1);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLUMNS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROW_PAIRS - 1);
  localparam logic [P_W-1:0]    P_LAST   = P_W'(BPP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_BLANK   = 3'd2,
    S_LATCH   = 3'd3,
    S_DISPLAY = 3'd4
  } state_e;

  // Display time of plane p in clk cycles.
  function automatic logic [T_W-1:0] disp_len(input logic [P_W-1:0] p);
    return T_W'(DISP_BASE) << p;
  endfunction

  // Number of display cycles with OE active: (len * brightness) >> 8.
  function automatic logic [T_W-1:0] on_ticks(input logic [P_W-1:0] p,
                                               input logic [7:0]     b);
    logic [T_W+7:0] prod;
    prod = {8'd0, disp_len(p)} * {{T_W{1'b0}}, b};
    return prod[T_W+7:8];
  endfunction

  // Bit p of each colour field, packed {R,G,B}.
  function automatic logic [2:0] plane_bits(input logic [3*BPP-1:0] px,
                                            input logic [P_W-1:0]   p);
    logic [BPP-1:0] rf;
    logic [BPP-1:0] gf;
    logic [BPP-1:0] bf;
    rf = px[3*BPP-1 -: BPP];
    gf = px[2*BPP-1 -: BPP];
    bf = px[BPP-1:0];
    return {rf[p], gf[p], bf[p]};
  endfunction

  state_e              state_q, state_d;
  logic                fetch_q, fetch_d;   // SHIFT sub-cycle that reads column 0
  logic                phase_q, phase_d;   // 0: data setup, 1: clk_out high
  logic [COL_W-1:0]    c_q, c_d;
  logic [ADDR_W-1:0]   r_q, r_d;
  logic [P_W-1:0]      p_q, p_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [7:0]          bright_q, bright_d;
  logic                frame_end_s;
  logic                last_tick_s;

  logic                fb_rd_en_q, fb_rd_en_d;
  logic [ADDR_W+COL_W-1:0] fb_addr_q, fb_addr_d;
  logic [COL_W-1:0]    rd_col_s;
  logic                rd_s;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                oe_q, oe_d;
  logic                latch_q, latch_d;
  logic                clk_out_q, clk_out_d;
  logic                frame_done_q, frame_done_d;
  logic [2:0]          rgb0_q, rgb1_q;
  logic                live_s;
  logic [2:0]          live0_s, live1_s;

  assign last_tick_s = (t_q == (disp_len(p_q) - T_W'(1)));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fetch_q  <= 1'b0;
      phase_q  <= 1'b0;
      c_q      <= '0;
      r_q      <= '0;
      p_q      <= '0;
      t_q      <= '0;
      bright_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      fetch_q  <= fetch_d;
      phase_q  <= phase_d;
      c_q      <= c_d;
      r_q      <= r_d;
      p_q      <= p_d;
      t_q      <= t_d;
      bright_q <= bright_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d     = state_q;
    fetch_d     = fetch_q;
    phase_d     = phase_q;
    c_d         = c_q;
    r_d         = r_q;
    p_d         = p_q;
    t_d         = t_q;
    bright_d    = bright_q;
    frame_end_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SHIFT;
          fetch_d = 1'b1;
          phase_d = 1'b0;
          c_d     = '0;
          r_d     = '0;
          p_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (fetch_q) begin
          fetch_d = 1'b0;
          phase_d = 1'b0;
          c_d     = '0;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (c_q == COL_LAST) begin
            state_d = S_BLANK;
            c_d     = '0;
          end else begin
            c_d = c_q + COL_W'(1);
          end
        end
      end
      S_BLANK: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        state_d  = S_DISPLAY;
        t_d      = '0;
        bright_d = brightness;
      end
      S_DISPLAY: begin
        if (last_tick_s) begin
          t_d = '0;
          if (p_q != P_LAST) begin
            p_d     = p_q + P_W'(1);
            state_d = S_SHIFT;
            fetch_d = 1'b1;
          end else begin
            p_d = '0;
            r_d = r_q + ADDR_W'(1);   // power-of-two row count wraps naturally
            if (r_q == ROW_LAST) begin
              frame_end_s = 1'b1;
              if (enable) begin
                state_d = S_SHIFT;
                fetch_d = 1'b1;
              end else begin
                state_d = S_IDLE;
                fetch_d = 1'b0;
              end
            end else begin
              state_d = S_SHIFT;
              fetch_d = 1'b1;
            end
          end
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the output registers line up
  // with the state register.
  always_comb begin
    rd_s     = (state_d == S_SHIFT) &&
               (fetch_d || (phase_d && (c_d != COL_LAST)));
    rd_col_s = fetch_d ? '0 : (c_d + COL_W'(1));
    fb_rd_en_d = rd_s;
    if (rd_s) begin
      fb_addr_d = {r_d, rd_col_s};
    end else begin
      fb_addr_d = fb_addr_q;
    end
    clk_out_d = (state_d == S_SHIFT) && !fetch_d && phase_d;
    if ((state_d == S_DISPLAY) && (t_d < on_ticks(p_d, bright_d))) begin
      oe_d = 1'b0;
    end else begin
      oe_d = 1'b1;
    end
    latch_d = (state_d == S_LATCH);
    if (state_d == S_BLANK) begin
      addr_d = r_d;
    end else begin
      addr_d = addr_q;
    end
    frame_done_d = frame_end_s;
  end

  // Panel and framebuffer output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_rd_en_q   <= 1'b0;
      fb_addr_q    <= '0;
      addr_q       <= '0;
      oe_q         <= 1'b1;
      latch_q      <= 1'b0;
      clk_out_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fb_rd_en_q   <= fb_rd_en_d;
      fb_addr_q    <= fb_addr_d;
      addr_q       <= addr_d;
      oe_q         <= oe_d;
      latch_q      <= latch_d;
      clk_out_q    <= clk_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Framebuffer data arrives during phase 0 itself, so that phase passes the
  // selected bits straight through (settled before clk_out rises); the value
  // is captured for phase 1 and cleared once shifting ends.
  assign live_s  = (state_q == S_SHIFT) && !fetch_q && !phase_q;
  assign live0_s = plane_bits(fb_data0, p_q);
  assign live1_s = plane_bits(fb_data1, p_q);

  // Colour hold registers for shift phase 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb0_q <= 3'b000;
      rgb1_q <= 3'b000;
    end else if (live_s) begin
      rgb0_q <= live0_s;
      rgb1_q <= live1_s;
    end else if (state_d != S_SHIFT) begin
      rgb0_q <= 3'b000;
      rgb1_q <= 3'b000;
    end else begin
      rgb0_q <= rgb0_q;
      rgb1_q <= rgb1_q;
    end
  end

  assign fb_rd_en   = fb_rd_en_q;
  assign fb_addr    = fb_addr_q;
  assign ADDR       = addr_q;
  assign OE         = oe_q;
  assign LATCH      = latch_q;
  assign clk_out    = clk_out_q;
  assign frame_done = frame_done_q;
  assign RGB0       = live_s ? live0_s : rgb0_q;
  assign RGB1       = live_s ? live1_s : rgb1_q;

endmodule
